tlc_input_conditioner: RTL

- Front-end stage directly upstream of the traffic light controller FSM.
- Synchronizes and debounces the raw walk_button and sensor inputs.
- Latches a pedestrian walk request until the controller acknowledges it.
- Generates the 1-second timing enable pulse that the controller's state counter advances on.

---
 rtl/tlc_pkg.sv | 18 +
 rtl/tlc_debounce.sv | 54 +++++
 rtl/tlc_input_conditioner.sv | 78 +++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller slice: default timing
// constants for the input conditioner and the controller state encoding.
package tlc_pkg;

    // 1 s tick and 10 ms debounce window at a 100 MHz system clock
    localparam int TICK_DIV_DEFAULT   = 100_000_000;
    localparam int DEB_CYCLES_DEFAULT = 1_000_000;

    // Controller states, shared by the controller FSM and its benches
    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        WALK        = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4
    } tlc_state_t;

endpackage

// File: rtl/tlc_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce counter.
// 'stable' is the registered debounced level. 'rise' is high during the cycle
// whose closing edge moves 'stable' from 0 to 1; it depends only on flops, so
// a parent can register it to produce a pulse aligned with the level change.
module tlc_debounce
    import tlc_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int            CW      = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          settle;

    assign settle = (s2 != stable) && (cnt == CNT_MAX);
    assign rise   = settle && s2;

    // Bring the asynchronous input into the clock domain; s1 feeds only s2
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Accept a new level only after it has differed for DEB_CYCLES straight edges
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tlc_input_conditioner.sv
// Front end of the traffic light controller: conditions the pedestrian button
// and side-street sensor, latches walk requests until the controller clears
// them, and produces the free-running 1 s tick the controller times against.
module tlc_input_conditioner
    import tlc_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic walk_button,
    input  logic sensor,
    input  logic walk_clear,
    output logic tick,
    output logic walk_req,
    output logic walk_press,
    output logic sensor_db
);

    localparam int            TW       = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    logic          walk_stable;
    logic          walk_rise;
    logic          sensor_rise_unused;
    logic [TW-1:0] tick_cnt;

    tlc_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_walk_deb (
        .clk    (clk),
        .rst    (rst),
        .raw    (walk_button),
        .stable (walk_stable),
        .rise   (walk_rise)
    );

    tlc_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_sensor_deb (
        .clk    (clk),
        .rst    (rst),
        .raw    (sensor),
        .stable (sensor_db),
        .rise   (sensor_rise_unused)
    );

    // Free-running divider; tick is high for the one cycle after each wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (tick_cnt == TICK_MAX) begin
            tick_cnt <= '0;
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
            tick     <= 1'b0;
        end
    end

    // Press pulse and request latch; a press on the clearing edge wins so it is never lost
    always_ff @(posedge clk) begin
        if (rst) begin
            walk_press <= 1'b0;
            walk_req   <= 1'b0;
        end else begin
            walk_press <= walk_rise;
            walk_req   <= walk_rise || (walk_req && !walk_clear);
        end
    end

    // The walk level itself is only observed through its press/request outputs
    logic walk_stable_unused;
    assign walk_stable_unused = walk_stable;

endmodule
